pc_ir_datapath: RTL
===================

Name: pc_ir_datapath

Overview:
- Multicycle MIPS datapath slice directly downstream of the main control FSM.
- Holds the architectural state registers: PC, Instruction Register (IR), Memory Data Register (MDR) and ALUOut.
- Consumes the FSM's PCWrite, Branch, NEF, PCSrc, IorD and IRWrite.
- Produces the memory address, decoded instruction fields (including Op, which feeds back to the FSM) and the sign-extended immediate.

Parameters:
- DATA_W, 32, datapath width. The jump-target formation and Op/field slicing are fixed to 32-bit MIPS encoding; only 32 is supported.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_write  input  1  unconditional PC update (FSM PCWrite).
- branch  input  1  conditional PC update (FSM Branch).
- nef  input  1  branch polarity: 0 = beq (take on zero), 1 = bne (take on !zero).
- pc_src  input  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 reserved.
- iord  input  1  memory address select: 0 = pc, 1 = alu_out.
- ir_write  input  1  IR load enable.
- alu_result  input  DATA_W  combinational ALU result of the current cycle.
- zero  input  1  ALU zero flag of the current cycle.
- mem_rdata  input  DATA_W  memory read data; combinational and valid in the same cycle as mem_addr.
- mem_addr  output  DATA_W  memory address.
- pc  output  DATA_W  current PC register.
- instr  output  DATA_W  IR contents.
- op  output  6  instr[31:26], to the FSM.
- rs, rt, rd  output  5 each  instr[25:21], instr[20:16], instr[15:11].
- funct  output  6  instr[5:0].
- sign_imm  output  DATA_W  instr[15:0] sign-extended.
- mdr  output  DATA_W  MDR contents.
- alu_out  output  DATA_W  ALUOut register.
- pc_en  output  1  effective PC write enable for the current cycle.

Behaviour:
- Reset (clk edge with reset=1):
  - pc=RESET_PC; instr=0; mdr=0; alu_out=0.
  - Reset overrides every write enable in the same cycle.
  - Mid-instruction reset discards all in-flight state. After reset, op=0, so the decode outputs are benign.
- PC enable (combinational): pc_en = pc_write | (branch & (zero ^ nef)).
- Next-PC mux:
  - 00 → alu_result (PC+4).
  - 01 → alu_out (branch target computed in decode).
  - 10 → {pc[31:28], instr[25:0], 2'b00}. pc here is the already-incremented PC, per multicycle convention.
  - 11 → current pc. PC holds even if pc_en=1; this is a reserved encoding, not an error.
- PC register: loads the next-PC value on an edge where pc_en=1; otherwise holds.
- PC stores the value unmodified: no alignment forcing and no overflow detection. 32'hFFFF_FFFC + 4 arrives from the ALU as 0 and is stored as 0.
- IR: loads mem_rdata when ir_write=1; otherwise holds.
- MDR: loads mem_rdata every cycle, unconditionally.
- ALUOut: loads alu_result every cycle, unconditionally.
- mem_addr (combinational): iord ? alu_out : pc.
- Simultaneous events:
  - ir_write=1 and pc_en=1 in the same cycle (fetch state): IR captures the word at the pre-update PC, and PC advances. No forwarding of the new PC into mem_addr.
  - branch=1 and pc_write=1 together: pc_en=1 regardless of zero.
- Field outputs and sign_imm are pure combinational slices of the registered IR, so they are stable for the whole instruction after fetch.
- Latency:
  - New PC is visible one cycle after the enable.
  - op is valid at the decode state, one cycle after the IR load.
- Every output is defined; no X propagates from reserved pc_src.

Decomposition:
- Shared package (mips_pkg):
  - PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10.
  - Opcode constants OP_RTYPE=6'h00, OP_J=6'h02, OP_BEQ=6'h04, OP_BNE=6'h05, OP_ADDI=6'h08, OP_LW=6'h23, OP_SW=6'h2b.
  - Field bit positions.
- One sub-module: en_reg, a parameterised-width register with synchronous reset, reset value and load enable.
  - Instantiated for PC, IR, MDR and ALUOut; MDR and ALUOut have the enable tied to 1.
- Next-PC mux and pc_en logic stay inline in the top module.

Test Plan:
- Reset release: reset=1 for 2 cycles with pc_write=1 and alu_result=32'h10 → after reset, pc=0, instr=0, mdr=0, alu_out=0. The reset cycle ignores pc_write.
- Fetch: pc=0, mem_rdata=32'h8C08_0004, ir_write=1, pc_write=1, pc_src=00, alu_result=4 → next cycle instr=32'h8C08_0004, op=6'h23, rt=8, sign_imm=4, pc=4. mem_addr was 0 during fetch.
- beq/bne: alu_out=32'h40, pc_src=01, branch=1:
  - nef=0, zero=1 → pc=32'h40.
  - nef=0, zero=0 → pc unchanged.
  - nef=1, zero=0 → pc=32'h40.
  - nef=1, zero=1 → pc unchanged.
- Jump: pc=32'hA000_0004, instr=32'h0800_0010, pc_src=10, pc_write=1 → pc=32'hA000_0040.
- Memory path:
  - iord=1 with alu_out=32'h100 → mem_addr=32'h100.
  - MDR captures mem_rdata=32'hDEAD_BEEF next cycle while instr holds.
  - sign_imm for instr[15:0]=16'h8000 is 32'hFFFF_8000.
- Reserved and mid-operation reset: pc_src=11 with pc_write=1 → pc holds. Asserting reset during a branch cycle → pc=RESET_PC; branch ignored.

Source files
------------

// File: rtl/pc_ir_datapath_pkg.sv
// Shared MIPS encoding constants for the multicycle datapath slice:
// next-PC selects, opcodes, instruction field positions and immediate extension.
package mips_pkg;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam int OP_MSB     = 31;
  localparam int OP_LSB     = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;
  localparam int PCHI_MSB   = 31;
  localparam int PCHI_LSB   = 28;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc_now,
                                              input logic [31:0] instr_now);
    return {pc_now[PCHI_MSB:PCHI_LSB], instr_now[JADDR_MSB:JADDR_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/pc_ir_datapath_en_reg.sv
// Parameterised register with synchronous active-high reset to a
// configurable value and a load enable; holds its value otherwise.
module en_reg #(
  parameter int              W       = 32,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // state update: reset wins over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pc_ir_datapath.sv
// Multicycle MIPS PC/IR/MDR/ALUOut datapath slice driven by the main control FSM;
// produces the memory address, decoded instruction fields and sign-extended immediate.
module pc_ir_datapath
  import mips_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              branch,
  input  logic              nef,
  input  logic [1:0]        pc_src,
  input  logic              iord,
  input  logic              ir_write,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] sign_imm,
  output logic [DATA_W-1:0] mdr,
  output logic [DATA_W-1:0] alu_out,
  output logic              pc_en
);

  logic              pc_en_s;
  logic [DATA_W-1:0] pc_next_s;
  logic [DATA_W-1:0] pc_r;
  logic [DATA_W-1:0] instr_r;
  logic [DATA_W-1:0] mdr_r;
  logic [DATA_W-1:0] alu_out_r;

  // branch taken when zero disagrees with the polarity bit (beq: zero, bne: !zero)
  always_comb begin
    pc_en_s = pc_write | (branch & (zero ^ nef));
  end

  // next-PC select; the reserved encoding recirculates the current PC
  always_comb begin
    pc_next_s = pc_r;
    case (pc_src)
      PCSRC_ALU:    pc_next_s = alu_result;
      PCSRC_ALUOUT: pc_next_s = alu_out_r;
      PCSRC_JUMP:   pc_next_s = jump_target(pc_r, instr_r);
      default:      pc_next_s = pc_r;
    endcase
  end

  // memory address select; fetch uses the pre-update PC, no forwarding
  always_comb begin
    if (iord) begin
      mem_addr = alu_out_r;
    end else begin
      mem_addr = pc_r;
    end
  end

  en_reg #(.W(DATA_W), .RST_VAL(RESET_PC)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en_s),
    .d     (pc_next_s),
    .q     (pc_r)
  );

  en_reg #(.W(DATA_W), .RST_VAL(32'h0000_0000)) u_ir (
    .clk   (clk),
    .reset (reset),
    .en    (ir_write),
    .d     (mem_rdata),
    .q     (instr_r)
  );

  en_reg #(.W(DATA_W), .RST_VAL(32'h0000_0000)) u_mdr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (mem_rdata),
    .q     (mdr_r)
  );

  en_reg #(.W(DATA_W), .RST_VAL(32'h0000_0000)) u_alu_out (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (alu_result),
    .q     (alu_out_r)
  );

  // decode outputs are slices of the registered IR, stable for the instruction
  always_comb begin
    pc       = pc_r;
    instr    = instr_r;
    mdr      = mdr_r;
    alu_out  = alu_out_r;
    pc_en    = pc_en_s;
    op       = instr_r[OP_MSB:OP_LSB];
    rs       = instr_r[RS_MSB:RS_LSB];
    rt       = instr_r[RT_MSB:RT_LSB];
    rd       = instr_r[RD_MSB:RD_LSB];
    funct    = instr_r[FUNCT_MSB:FUNCT_LSB];
    sign_imm = sign_ext16(instr_r[IMM_MSB:IMM_LSB]);
  end

endmodule
